// File: rtl/hog_cell_hist.sv
// Accumulates gradient magnitudes into 9-bin histograms over 8x8 cells of a raster frame.
// Emits one cell per o_valid pulse, at least OUT_GAP cycles apart; stalls completing pixels when the FIFO is full.
module hog_cell_hist #(
  parameter int BIN_I   = 16,
  parameter int BIN_F   = 4,
  parameter int MAG_I   = 8,
  parameter int MAG_F   = 4,
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int OUT_GAP = 80,
  localparam int BIN_W  = BIN_I + BIN_F,
  localparam int MAG_W  = MAG_I + MAG_F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAG_W-1:0]     mag,
  input  logic [3:0]           bin_idx,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [9*BIN_W-1:0]   bin,
  output logic                 o_valid
);

  localparam int CELLS_X = IMG_W / 8;
  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = $clog2(IMG_H);
  localparam int CXW     = XW - 3;
  localparam int PW      = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int CNTW    = $clog2(CELLS_X + 1);
  localparam int GW      = $clog2(OUT_GAP + 1);

  typedef logic [8:0][BIN_W-1:0] hist_t;

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  hist_t           acc_q, acc_d;
  logic            push_vld_q, push_vld_d;
  hist_t           push_dat_q, push_dat_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  hist_t           bin_q, bin_d;
  logic            o_valid_q, o_valid_d;

  hist_t           pbuf_q [CELLS_X];
  hist_t           fifo_q [CELLS_X];

  logic [3:0]      bin_c;
  logic [BIN_W-1:0] mag_ext;
  logic [CXW-1:0]  cx;
  logic            seg_end, cell_done, fifo_full, i_ready_c, accept;
  hist_t           entry, seg_sum, cell_sum;
  logic            pbuf_we;
  hist_t           pbuf_wdat;
  logic            pop, fifo_we, fifo_rd;
  hist_t           out_dat;

  always_comb begin
    bin_c     = (bin_idx > 4'd8) ? 4'd8 : bin_idx;
    mag_ext   = BIN_W'(mag);
    cx        = x_q[XW-1:3];
    seg_end   = (x_q[2:0] == 3'd7);
    cell_done = seg_end && (y_q[2:0] == 3'd7);
    // in-flight push counts as occupied so the pushed cell always has a slot
    fifo_full = (int'(cnt_q) + int'(push_vld_q)) >= CELLS_X;
    i_ready_c = !(fifo_full && cell_done);
    accept    = i_valid && i_ready_c;
    entry     = pbuf_q[cx];
    for (int k = 0; k < 9; k++) begin
      seg_sum[k]  = acc_q[k] + ((bin_c == 4'(k)) ? mag_ext : '0);
      cell_sum[k] = entry[k] + seg_sum[k];
    end

    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    pbuf_we    = 1'b0;
    pbuf_wdat  = (y_q[2:0] == 3'd0) ? seg_sum : cell_sum;
    push_vld_d = 1'b0;
    push_dat_d = push_dat_q;
    if (accept) begin
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      acc_d = seg_end ? '0 : seg_sum;
      if (cell_done) begin
        push_vld_d = 1'b1;
        push_dat_d = cell_sum;
      end else if (seg_end) begin
        pbuf_we = 1'b1;
      end
    end

    // an empty FIFO forwards the in-flight push directly to the output register
    pop      = (gap_q == '0) && ((cnt_q != '0) || push_vld_q);
    out_dat  = (cnt_q == '0) ? push_dat_q : fifo_q[rd_ptr_q];
    fifo_we  = push_vld_q && !((cnt_q == '0) && pop);
    fifo_rd  = pop && (cnt_q != '0);
    cnt_d    = cnt_q + CNTW'(fifo_we) - CNTW'(fifo_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_we) wr_ptr_d = (wr_ptr_q == PW'(CELLS_X - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_rd) rd_ptr_d = (rd_ptr_q == PW'(CELLS_X - 1)) ? '0 : rd_ptr_q + 1'b1;

    if (pop)                gap_d = GW'(OUT_GAP - 1);
    else if (gap_q != '0)   gap_d = gap_q - 1'b1;
    else                    gap_d = gap_q;
    bin_d     = pop ? out_dat : bin_q;
    o_valid_d = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      push_vld_q <= 1'b0;
      push_dat_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      bin_q      <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      push_vld_q <= push_vld_d;
      push_dat_q <= push_dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      bin_q      <= bin_d;
      o_valid_q  <= o_valid_d;
    end
  end

  // storage arrays carry no reset; cell row 0 rewrites every partial entry
  always_ff @(posedge clk) begin
    if (pbuf_we) pbuf_q[cx] <= pbuf_wdat;
    if (fifo_we) fifo_q[wr_ptr_q] <= push_dat_q;
  end

  assign i_ready = i_ready_c;
  assign bin     = bin_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_hog_cell_hist.sv
// Scoreboard bench for hog_cell_hist on a reduced 64x24 frame (8x3 cells).
`timescale 1ns/1ps
module tb_hog_cell_hist;
  localparam int BIN_W   = 20;
  localparam int MAG_W   = 12;
  localparam int IMG_W   = 64;
  localparam int IMG_H   = 24;
  localparam int OUT_GAP = 120;
  localparam int CELLS_X = IMG_W / 8;
  localparam int CELLS_Y = IMG_H / 8;
  localparam int NCELLS  = CELLS_X * CELLS_Y;

  typedef logic [9*BIN_W-1:0] hv_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [MAG_W-1:0] mag;
  logic [3:0]       bin_idx;
  logic             i_valid;
  logic             i_ready;
  hv_t              bin;
  logic             o_valid;

  hv_t exp_q[$];
  hv_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  epoch = 0;
  int  last_epoch = -1;
  int  last_pulse = 0;
  int  first_pulse = 0;
  int  min_gap = 0;
  int  pulse_cnt = 0;
  int  stalls = 0;

  hog_cell_hist #(
    .BIN_I(16), .BIN_F(4), .MAG_I(8), .MAG_F(4),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_GAP(OUT_GAP)
  ) dut (
    .clk(clk), .rst(rst), .mag(mag), .bin_idx(bin_idx),
    .i_valid(i_valid), .i_ready(i_ready), .bin(bin), .o_valid(o_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid && mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got bin=%h, none expected", bin);
      end else begin
        mon_e = exp_q.pop_front();
        if (bin !== mon_e) begin
          errors++;
          $display("FAIL cell_hist: got %h want %h", bin, mon_e);
        end
      end
      if (epoch != last_epoch) begin
        last_epoch  = epoch;
        first_pulse = cyc;
        min_gap     = 1 << 30;
      end else begin
        checks++;
        if (cyc - last_pulse < OUT_GAP) begin
          errors++;
          $display("FAIL pulse_gap: got %0d cycles want >= %0d", cyc - last_pulse, OUT_GAP);
        end
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      end
      last_pulse = cyc;
      pulse_cnt++;
    end
  end

  task automatic chk(input string n, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask

  function automatic hv_t exp_cell(input int mode, input int cx, input int cy);
    hv_t v;
    v = '0;
    case (mode)
      1:       v[0*BIN_W +: BIN_W] = 20'h00400;
      2:       v[8*BIN_W +: BIN_W] = 20'h00400;
      3:       v[3*BIN_W +: BIN_W] = 20'h3FFC0;
      default: v[(cx % 9)*BIN_W +: BIN_W] = BIN_W'(64 * (cx + cy));
    endcase
    return v;
  endfunction

  // Starts and ends #1 after a rising edge; returns the cycle the beat was accepted in.
  task automatic px(input logic [MAG_W-1:0] m, input logic [3:0] b, input int idle, output int t);
    int w;
    i_valid = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    mag     = m;
    bin_idx = b;
    w = 0;
    @(negedge clk);
    while (!i_ready) begin
      stalls++;
      w++;
      if (w > 20000) begin
        errors++;
        $display("FAIL stall_timeout: i_ready low for %0d cycles", w);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
      @(negedge clk);
    end
    t = cyc;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int idle_pct, input bit expect_on,
                           input int stop_after, output int t_first);
    int n, t, idle, cx, cy;
    logic [MAG_W-1:0] m;
    logic [3:0] b;
    n = 0;
    t_first = 0;
    if (expect_on)
      for (int j = 0; j < CELLS_Y; j++)
        for (int i = 0; i < CELLS_X; i++)
          exp_q.push_back(exp_cell(mode, i, j));
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        cx = x / 8;
        cy = y / 8;
        case (mode)
          1:       begin m = 12'h010; b = 4'd0;  end
          2:       begin m = 12'h010; b = 4'd12; end
          3:       begin m = 12'hFFF; b = 4'd3;  end
          default: begin m = MAG_W'(cx + cy); b = 4'(cx % 9); end
        endcase
        idle = ($urandom_range(0, 99) < idle_pct) ? $urandom_range(1, 3) : 0;
        px(m, b, idle, t);
        if (x == 7 && y == 7) t_first = t;
        n++;
        if (stop_after > 0 && n >= stop_after) return;
      end
    end
  endtask

  task automatic drain(input string n);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 30000) begin
      @(posedge clk);
      w++;
    end
    chk(n, 192'(exp_q.size()), 192'(0));
    repeat (OUT_GAP + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    int t, pc0, st0;
    rst = 1'b1; i_valid = 1'b0; mag = '0; bin_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_o_valid", 192'(o_valid), 192'(0));
    chk("reset_bin", 192'(bin), 192'(0));
    chk("reset_i_ready", 192'(i_ready), 192'(1));
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    epoch  = 1;

    pc0 = pulse_cnt;
    run_frame(1, 0, 1'b1, 0, t);
    drain("drain_bin0");
    chk("count_bin0", 192'(pulse_cnt - pc0), 192'(NCELLS));
    chk("bin_hold", 192'(bin), 192'(exp_cell(1, CELLS_X - 1, CELLS_Y - 1)));

    pc0 = pulse_cnt;
    run_frame(2, 10, 1'b1, 0, t);
    drain("drain_clamp");
    chk("count_clamp", 192'(pulse_cnt - pc0), 192'(NCELLS));

    run_frame(3, 0, 1'b1, 0, t);
    drain("drain_maxmag");

    epoch++;
    st0 = stalls;
    pc0 = pulse_cnt;
    run_frame(1, 0, 1'b1, 0, t);
    drain("drain_fullrate");
    chk("count_fullrate", 192'(pulse_cnt - pc0), 192'(NCELLS));
    chk("first_latency", 192'(first_pulse - t), 192'(2));
    chk("stall_seen", 192'(stalls > st0), 192'(1));
    chk("min_gap", 192'(min_gap), 192'(OUT_GAP));

    run_frame(5, 30, 1'b1, 0, t);
    drain("drain_gappy");
    run_frame(5, 0, 1'b1, 0, t);
    drain("drain_ramp_full");

    mon_en = 1'b0;
    run_frame(1, 0, 1'b0, 1000, t);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", 192'(o_valid), 192'(0));
    chk("midrst_i_ready", 192'(i_ready), 192'(1));
    @(posedge clk);
    #1;
    epoch++;
    mon_en = 1'b1;
    pc0 = pulse_cnt;
    run_frame(1, 0, 1'b1, 0, t);
    drain("drain_after_rst");
    chk("count_after_rst", 192'(pulse_cnt - pc0), 192'(NCELLS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
